writeback_register_file: RTL and testbench

Consumer end of the memory-to-writeback pipeline register: the writeback stage plus the architectural register file.
- Selects the writeback result from the W-stage fields.
- Commits the result to a 32x32 register file (x0 hardwired to zero).
- Serves the two decode-stage read ports, with same-cycle write-through bypass.
- Keeps a 64-bit retired-instruction counter.

---
 rtl/writeback_register_file.sv | 75 +++++++
 tb/tb_writeback_register_file.sv | 123 ++++++++++++
 2 files changed

// File: rtl/writeback_register_file.sv
// Writeback stage and architectural register file: result select, 32x32 regfile with x0 = 0,
// two async read ports and a retired-instruction counter. Define WB_BYPASS_EN for write-through.
module writeback_register_file #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ValidW,
  input  logic                     RegWriteW,
  input  logic [1:0]               ResultSrcW,
  input  logic [XLEN-1:0]          ALUResultW,
  input  logic [XLEN-1:0]          ReadDataW,
  input  logic [XLEN-1:0]          PCPlus4W,
  input  logic [$clog2(NREGS)-1:0] RdW,
  input  logic [$clog2(NREGS)-1:0] Rs1D,
  input  logic [$clog2(NREGS)-1:0] Rs2D,
  output logic [XLEN-1:0]          RD1D,
  output logic [XLEN-1:0]          RD2D,
  output logic [XLEN-1:0]          ResultW,
  output logic [CNT_W-1:0]         InstRetW
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [CNT_W-1:0] inst_ret_q;
  logic             we;

  always_comb begin
    ResultW = '0;
    case (ResultSrcW)
      2'b00:   ResultW = ALUResultW;
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = '0;
    endcase
  end

  // ValidW gates first so X on the other W-stage fields cannot enable a write.
  assign we = ValidW & RegWriteW & (RdW != '0) & ~rst;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (rst || i == 0) begin
        regs_q[i] <= '0;
      end else if (we && RdW == AW'(i)) begin
        regs_q[i] <= ResultW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_ret_q <= '0;
    end else if (ValidW) begin
      inst_ret_q <= inst_ret_q + CNT_W'(1);
    end
  end

  assign InstRetW = inst_ret_q;

  always_comb begin
    RD1D = (Rs1D == '0) ? '0 : regs_q[Rs1D];
    RD2D = (Rs2D == '0) ? '0 : regs_q[Rs2D];
`ifdef WB_BYPASS_EN
    if (we && Rs1D == RdW) RD1D = ResultW;
    if (we && Rs2D == RdW) RD2D = ResultW;
`else
    // Stored value only; the hazard unit covers the W->D window.
`endif
  end

endmodule

// File: tb/tb_writeback_register_file.sv
// Bench for writeback_register_file: directed plan steps plus random traffic against an
// array-based reference model; a 4-bit-counter instance covers counter wrap.
module tb_writeback_register_file;

  logic        clk = 1'b0;
  logic        rst, ValidW, RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW, Rs1D, Rs2D;
  logic [31:0] RD1D, RD2D, ResultW;
  logic [63:0] InstRetW;
  logic [31:0] s_rd1, s_rd2, s_res;
  logic [3:0]  s_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] m_regs [32];
  logic [63:0] m_cnt;

  always #5 clk = ~clk;

  writeback_register_file dut (
    .clk(clk), .rst(rst), .ValidW(ValidW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW), .InstRetW(InstRetW)
  );

  writeback_register_file #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .ValidW(ValidW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(s_rd1), .RD2D(s_rd2), .ResultW(s_res), .InstRetW(s_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive after the edge, check at negedge, then advance the model.
  task automatic step(input logic r, input logic v, input logic rw, input logic [1:0] src,
                      input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    logic [31:0] res, e1, e2;
    logic        wr;
    @(posedge clk);
    #1;
    rst = r; ValidW = v; RegWriteW = rw; ResultSrcW = src;
    ALUResultW = alu; ReadDataW = rdat; PCPlus4W = pc; RdW = rd; Rs1D = rs1; Rs2D = rs2;
    @(negedge clk);
    res = (src == 2'd0) ? alu : (src == 2'd1) ? rdat : (src == 2'd2) ? pc : 32'd0;
    wr  = v && rw && rd != 5'd0 && !r;
    e1  = m_regs[rs1];
    e2  = m_regs[rs2];
`ifdef WB_BYPASS_EN
    if (wr && rs1 == rd) e1 = res;
    if (wr && rs2 == rd) e2 = res;
`endif
    check("result", {32'd0, ResultW}, {32'd0, res});
    check("rd1", {32'd0, RD1D}, {32'd0, e1});
    check("rd2", {32'd0, RD2D}, {32'd0, e2});
    check("instret", InstRetW, m_cnt);
    check("instret4", {60'd0, s_cnt}, {60'd0, m_cnt[3:0]});
    if (r) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_cnt = 64'd0;
    end else begin
      if (wr) m_regs[rd] = res;
      if (v) m_cnt = m_cnt + 64'd1;
    end
  endtask

  initial begin
    logic [4:0] rd;
    rst = 1'b1; ValidW = 1'b0; RegWriteW = 1'b0; ResultSrcW = 2'd0;
    ALUResultW = '0; ReadDataW = '0; PCPlus4W = '0; RdW = '0; Rs1D = '0; Rs2D = '0;
    repeat (2) @(posedge clk);
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_cnt = 64'd0;

    step(1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 2'd0, 0, 0, 0, 0, 5, 31);
    // Load to x3 with same-cycle read, then read it back.
    step(0, 1, 1, 2'd1, 0, 32'hDEAD_BEEF, 0, 3, 3, 0);
    step(0, 0, 0, 2'd0, 0, 0, 0, 0, 3, 3);
    // ResultSrcW sweep into x7.
    step(0, 1, 1, 2'd0, 1, 0, 32'h104, 7, 7, 0);
    step(0, 1, 1, 2'd2, 1, 0, 32'h104, 7, 7, 0);
    step(0, 1, 1, 2'd3, 1, 0, 32'h104, 7, 7, 7);
    step(0, 0, 0, 2'd0, 0, 0, 0, 0, 7, 7);
    // x0 write is dropped but still counts.
    step(0, 1, 1, 2'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    step(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    // Bubble with stale RegWriteW.
    step(0, 0, 1, 2'd0, 9, 0, 0, 4, 4, 4);
    step(0, 0, 0, 2'd0, 0, 0, 0, 0, 4, 4);
    // Counter wrap on the 4-bit instance.
    step(1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    check("wrap4", {60'd0, s_cnt}, 64'd0);
    // Reset concurrent with a write to x2.
    step(0, 1, 1, 2'd0, 10, 0, 0, 2, 2, 0);
    step(1, 1, 1, 2'd0, 11, 0, 0, 2, 2, 2);
    step(0, 0, 0, 2'd0, 0, 0, 0, 0, 2, 2);
    check("rst_cnt", InstRetW, 64'd0);

    for (int n = 0; n < 400; n++) begin
      rd = 5'($urandom_range(0, 31));
      step(($urandom_range(0, 40) == 0), 1'($urandom), 1'($urandom), 2'($urandom),
           $urandom, $urandom, $urandom, rd,
           ($urandom_range(0, 1) == 1) ? rd : 5'($urandom),
           ($urandom_range(0, 1) == 1) ? rd : 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
